// File: rtl/du_program_loader_pkg.sv
// Purpose: shared widths, execution-mode bytes and FSM encoding for the debug-unit program loader.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package du_program_loader_pkg;

    localparam int N_BITS_DATA = 8;       // UART byte width
    localparam int NB_DATA     = 32;      // instruction word width
    localparam int ADDRWIDTH   = 8;       // instruction memory word address, kept >= 8 so 255 words never wrap
    localparam int LANES       = NB_DATA / N_BITS_DATA;
    localparam int LANE_CNT_W  = $clog2(LANES);

    localparam logic [N_BITS_DATA-1:0] MODE_STEP = 8'h0F;
    localparam logic [N_BITS_DATA-1:0] MODE_CONT = 8'hF0;

    // Encoding is visible on state_o, so values are fixed rather than left to the tool.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WRITE     = 3'd2,
        ST_WAIT_MODE = 3'd3,
        ST_STEP      = 3'd4,
        ST_RUN       = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

endpackage

// File: rtl/du_word_assembler.sv
// Purpose: packs UART bytes little-endian into instruction words (byte 0 -> bits [7:0]).
// Latency: word_vld_o/word_dat_o register one cycle after the last byte strobe.
// Backpressure: none; every byte_vld_i strobe is consumed in the cycle it arrives.
module du_word_assembler
    import du_program_loader_pkg::*;
(
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   byte_vld_i,
    input  logic [N_BITS_DATA-1:0] byte_dat_i,
    output logic                   last_byte_o,
    output logic                   word_vld_o,
    output logic [NB_DATA-1:0]     word_dat_o
);

    logic [LANE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0]    shift_q, shift_d;
    logic [NB_DATA-1:0]    word_q, word_d;
    logic                  word_vld_q, word_vld_d;

    assign last_byte_o = byte_vld_i && (byte_cnt_q == LANE_CNT_W'(LANES - 1));
    assign word_vld_o  = word_vld_q;
    assign word_dat_o  = word_q;

    // Drop each byte into its lane; on the final lane publish the word and start a clean one.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        word_d     = word_q;
        word_vld_d = 1'b0;
        if (byte_vld_i) begin
            shift_d[int'(byte_cnt_q) * N_BITS_DATA +: N_BITS_DATA] = byte_dat_i;
            byte_cnt_d = byte_cnt_q + LANE_CNT_W'(1);
        end
        if (last_byte_o) begin
            word_d     = shift_d;
            word_vld_d = 1'b1;
            shift_d    = '0;
        end
    end

    // Lane counter, partial word and published word; reset drops any partial word.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
        end
    end

endmodule

// File: rtl/du_program_loader.sv
// Purpose: loads a host program from UART bytes into instruction memory, then gates pipeline stepping/running.
// Latency: write strobe one cycle after the 4th byte of a word; mode byte acts on the next cycle; halt gates enable combinationally in RUN.
// Backpressure: none; UART byte rate guarantees a strobe is never presented faster than it can be absorbed.
module du_program_loader
    import du_program_loader_pkg::*;
(
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   rx_valid_i,
    input  logic [N_BITS_DATA-1:0] rx_byte_i,
    input  logic                   halt_i,
    output logic                   inst_we_o,
    output logic [ADDRWIDTH-1:0]   inst_addr_o,
    output logic [NB_DATA-1:0]     inst_data_o,
    output logic                   enable_pipe_o,
    output logic                   ack_debug_o,
    output logic                   load_done_o,
    output logic                   end_o,
    output logic [2:0]             state_o
);

    state_e                 state_q, state_d;
    logic [7:0]             n_inst_q, n_inst_d;
    logic [7:0]             word_cnt_q, word_cnt_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic                   load_done_q, load_done_d;
    logic                   ack_q, ack_d;
    logic                   en_q, en_d;
    logic                   end_q, end_d;

    logic                   asm_vld;
    logic                   last_byte;
    logic                   word_vld;
    logic [NB_DATA-1:0]     word_dat;
    logic                   last_word;

    // Widened compare so a count of 255 never aliases through an 8-bit wrap.
    assign last_word = ((9'(word_cnt_q) + 9'd1) == 9'(n_inst_q));

    // Bytes belong to the program only while loading; a strobe during WRITE starts the next word,
    // unless that WRITE is the final one, in which case there is no next word to start.
    assign asm_vld = rx_valid_i &&
                     ((state_q == ST_LOAD) || ((state_q == ST_WRITE) && !last_word));

    du_word_assembler u_word_assembler (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .byte_vld_i  (asm_vld),
        .byte_dat_i  (rx_byte_i),
        .last_byte_o (last_byte),
        .word_vld_o  (word_vld),
        .word_dat_o  (word_dat)
    );

    // The assembler's word pulse lines up exactly with the WRITE state.
    assign inst_we_o     = word_vld;
    assign inst_data_o   = word_dat;
    assign inst_addr_o   = addr_q;
    assign ack_debug_o   = ack_q;
    assign load_done_o   = load_done_q;
    assign end_o         = end_q;
    assign state_o       = state_q;
    // In RUN the halt must stop the pipeline in the same cycle it is seen, hence the combinational gate.
    assign enable_pipe_o = en_q && !((state_q == ST_RUN) && halt_i);

    // Next-state and next-output decode; outputs are registered alongside the state.
    always_comb begin
        state_d     = state_q;
        n_inst_d    = n_inst_q;
        word_cnt_d  = word_cnt_q;
        addr_d      = addr_q;
        load_done_d = load_done_q;
        ack_d       = ack_q;
        en_d        = en_q;
        end_d       = end_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    n_inst_d = rx_byte_i;
                    if (rx_byte_i == '0) begin
                        state_d     = ST_WAIT_MODE;
                        load_done_d = 1'b1;
                        ack_d       = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (last_byte) begin
                    state_d = ST_WRITE;
                    addr_d  = ADDRWIDTH'(word_cnt_q);
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_q + 8'd1;
                if (last_word) begin
                    state_d     = ST_WAIT_MODE;
                    load_done_d = 1'b1;
                    ack_d       = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WAIT_MODE: begin
                if (rx_valid_i) begin
                    if (rx_byte_i == MODE_STEP) begin
                        state_d = ST_STEP;
                        ack_d   = 1'b0;
                        en_d    = 1'b1;
                    end else if (rx_byte_i == MODE_CONT) begin
                        state_d = ST_RUN;
                        ack_d   = 1'b0;
                        en_d    = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                en_d = 1'b0;
                if (halt_i) begin
                    state_d = ST_DONE;
                    end_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT_MODE;
                    ack_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_i) begin
                    state_d = ST_DONE;
                    en_d    = 1'b0;
                    end_d   = 1'b1;
                end
            end
            ST_DONE: begin
                // Terminal until reset; rx bytes and halt are irrelevant here.
            end
            default: begin
                state_d     = ST_IDLE;
                n_inst_d    = '0;
                word_cnt_d  = '0;
                addr_d      = '0;
                load_done_d = 1'b0;
                ack_d       = 1'b0;
                en_d        = 1'b0;
                end_d       = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs; async reset aborts any load in progress.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            n_inst_q    <= '0;
            word_cnt_q  <= '0;
            addr_q      <= '0;
            load_done_q <= 1'b0;
            ack_q       <= 1'b0;
            en_q        <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_inst_q    <= n_inst_d;
            word_cnt_q  <= word_cnt_d;
            addr_q      <= addr_d;
            load_done_q <= load_done_d;
            ack_q       <= ack_d;
            en_q        <= en_d;
            end_q       <= end_d;
        end
    end

endmodule

// File: tb/tb_du_program_loader.sv
// Purpose: self-checking bench for du_program_loader (load tables, mode sequences, randomized programs).
// Latency: n/a.
// Backpressure: n/a.
module tb_du_program_loader;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        halt_i = 1'b0;
    logic        inst_we_o;
    logic [7:0]  inst_addr_o;
    logic [31:0] inst_data_o;
    logic        enable_pipe_o;
    logic        ack_debug_o;
    logic        load_done_o;
    logic        end_o;
    logic [2:0]  state_o;

    du_program_loader dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .rx_valid_i    (rx_valid_i),
        .rx_byte_i     (rx_byte_i),
        .halt_i        (halt_i),
        .inst_we_o     (inst_we_o),
        .inst_addr_o   (inst_addr_o),
        .inst_data_o   (inst_data_o),
        .enable_pipe_o (enable_pipe_o),
        .ack_debug_o   (ack_debug_o),
        .load_done_o   (load_done_o),
        .end_o         (end_o),
        .state_o       (state_o)
    );

    always #5 clock_i = ~clock_i;

    int errors = 0;
    int checks = 0;
    int en_cycles = 0;
    logic [39:0] wq[$];          // observed writes: {addr, data}

    // Observe on the falling edge, away from the active edge.
    always @(negedge clock_i) begin
        if (inst_we_o) wq.push_back({inst_addr_o, inst_data_o});
        if (enable_pipe_o) en_cycles++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One-cycle byte strobe; returns on the falling edge after the DUT has sampled it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock_i);
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        @(negedge clock_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i    = 1'b0;
        rx_valid_i = 1'b0;
        halt_i     = 1'b0;
        repeat (2) @(negedge clock_i);
        wq.delete();
        en_cycles = 0;
        reset_i = 1'b1;
    endtask

    task automatic wait_load(input string name);
        int t = 0;
        while (!load_done_o && t < 200) begin
            @(negedge clock_i);
            t++;
        end
        chk({name, "_load_done"}, load_done_o, 1'b1);
    endtask

    // Reference: a program of n words must appear as writes (i, word_i) in order, nothing else.
    task automatic do_load(input string name, input int n, input logic [255:0] w, input int maxgap);
        wq.delete();
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(w[32*i + 8*b +: 8]);
                repeat ($urandom_range(0, maxgap)) @(negedge clock_i);
            end
        end
        wait_load(name);
        @(negedge clock_i);
        chk({name, "_wr_count"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk({name, "_wr_addr"}, 64'(wq[i][39:32]), 64'(i));
            chk({name, "_wr_data"}, 64'(wq[i][31:0]), 64'(w[32*i +: 32]));
        end
        chk({name, "_state_wait"}, 64'(state_o), 64'd3);
        chk({name, "_ack"}, 64'(ack_debug_o), 64'd1);
        chk({name, "_en_idle"}, 64'(enable_pipe_o), 64'd0);
    endtask

    typedef struct {
        int           n;
        logic [255:0] w;
        int           gap;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [255:0] w;
        int n, k, bad;
        logic [7:0] junk;

        tbl[0].n = 2; tbl[0].gap = 0; tbl[0].w = '0;
        tbl[0].w[31:0] = 32'h20010013; tbl[0].w[63:32] = 32'hFC000000;
        tbl[1].n = 0; tbl[1].gap = 0; tbl[1].w = '0;
        tbl[2].n = 1; tbl[2].gap = 2; tbl[2].w = '0;
        tbl[2].w[31:0] = 32'hDDCCBBAA;
        tbl[3].n = 5; tbl[3].gap = 0; tbl[3].w = '0;
        tbl[3].w[159:0] = 160'h0000_0001_8000_0000_FFFF_FFFF_0102_0304_A5A5_5A5A;
        tbl[4].n = 3; tbl[4].gap = 3; tbl[4].w = '0;
        tbl[4].w[95:0] = 96'h0F0F_F0F0_0000_00FF_1234_5678;

        // Reset state
        #1;
        chk("rst_we", 64'(inst_we_o), 0);
        chk("rst_addr", 64'(inst_addr_o), 0);
        chk("rst_data", 64'(inst_data_o), 0);
        chk("rst_en", 64'(enable_pipe_o), 0);
        chk("rst_ack", 64'(ack_debug_o), 0);
        chk("rst_done", 64'(load_done_o), 0);
        chk("rst_end", 64'(end_o), 0);
        chk("rst_state", 64'(state_o), 0);

        // Table-driven loads
        for (int t = 0; t < 5; t++) begin
            do_reset();
            do_load($sformatf("tbl%0d", t), tbl[t].n, tbl[t].w, tbl[t].gap);
        end

        // Test 1 timing: WRITE one cycle after the 4th byte, load_done/ack the cycle after the last WRITE
        do_reset();
        send_byte(8'd2);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h01); send_byte(8'h20);
        chk("t1_we0", 64'(inst_we_o), 1);
        chk("t1_addr0", 64'(inst_addr_o), 0);
        chk("t1_data0", 64'(inst_data_o), 64'h20010013);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFC);
        chk("t1_we1", 64'(inst_we_o), 1);
        chk("t1_addr1", 64'(inst_addr_o), 1);
        chk("t1_data1", 64'(inst_data_o), 64'hFC000000);
        chk("t1_done_early", 64'(load_done_o), 0);
        @(negedge clock_i);
        chk("t1_done", 64'(load_done_o), 1);
        chk("t1_ack", 64'(ack_debug_o), 1);
        chk("t1_we_low", 64'(inst_we_o), 0);
        chk("t1_addr_hold", 64'(inst_addr_o), 1);

        // Test 5: unknown mode byte ignored
        send_byte(8'h55);
        chk("t5_state", 64'(state_o), 3);
        chk("t5_ack", 64'(ack_debug_o), 1);
        chk("t5_en", 64'(enable_pipe_o), 0);

        // Test 3: three steps, then a step with halt
        en_cycles = 0;
        for (int s = 0; s < 3; s++) begin
            send_byte(8'h0F);
            chk("t3_pulse", 64'(enable_pipe_o), 1);
            chk("t3_ack_low", 64'(ack_debug_o), 0);
            @(negedge clock_i);
            chk("t3_pulse_end", 64'(enable_pipe_o), 0);
            chk("t3_ack_back", 64'(ack_debug_o), 1);
        end
        chk("t3_pulse_count", 64'(en_cycles), 3);
        halt_i = 1'b1;
        send_byte(8'h0F);
        chk("t3_last_pulse", 64'(enable_pipe_o), 1);
        @(negedge clock_i);
        chk("t3_end", 64'(end_o), 1);
        chk("t3_state_done", 64'(state_o), 6);
        chk("t3_en_off", 64'(enable_pipe_o), 0);
        chk("t3_ack_off", 64'(ack_debug_o), 0);
        chk("t3_pulse_total", 64'(en_cycles), 4);

        // Test 4: continuous run, halt after 20 cycles
        do_reset();
        do_load("t4", 1, 256'h1234_5678, 0);
        send_byte(8'hF0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (!enable_pipe_o) bad++;
            @(negedge clock_i);
        end
        chk("t4_run_en", 64'(bad), 0);
        halt_i = 1'b1;
        #1;
        chk("t4_halt_gate", 64'(enable_pipe_o), 0);
        chk("t4_end_not_yet", 64'(end_o), 0);
        @(negedge clock_i);
        chk("t4_end", 64'(end_o), 1);
        chk("t4_state_done", 64'(state_o), 6);
        halt_i = 1'b0;
        send_byte(8'h0F);
        @(negedge clock_i);
        chk("t4_ignored_state", 64'(state_o), 6);
        chk("t4_ignored_en", 64'(enable_pipe_o), 0);

        // Test 6: reset mid-load, then a clean reload
        do_reset();
        send_byte(8'd2);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        reset_i = 1'b0;
        #1;
        chk("t6_we", 64'(inst_we_o), 0);
        chk("t6_addr", 64'(inst_addr_o), 0);
        chk("t6_data", 64'(inst_data_o), 0);
        chk("t6_state", 64'(state_o), 0);
        chk("t6_done", 64'(load_done_o), 0);
        @(negedge clock_i);
        reset_i = 1'b1;
        do_load("t6_reload", 1, 256'hDDCC_BBAA, 1);

        // Randomized programs and mode sequences
        for (int r = 0; r < 6; r++) begin
            do_reset();
            n = $urandom_range(1, 8);
            w = '0;
            for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom();
            do_load($sformatf("rnd%0d", r), n, w, $urandom_range(0, 2));
            en_cycles = 0;
            k = 0;
            for (int s = 0; s < 6; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    send_byte(8'h0F);
                    k++;
                end else begin
                    junk = 8'($urandom());
                    if (junk == 8'h0F || junk == 8'hF0) junk = 8'h00;
                    send_byte(junk);
                end
                @(negedge clock_i);
            end
            chk("rnd_step_pulses", 64'(en_cycles), 64'(k));
            chk("rnd_step_state", 64'(state_o), 3);
            send_byte(8'hF0);
            repeat ($urandom_range(1, 10)) @(negedge clock_i);
            chk("rnd_run_en", 64'(enable_pipe_o), 1);
            halt_i = 1'b1;
            @(negedge clock_i);
            chk("rnd_run_end", 64'(end_o), 1);
            halt_i = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/du_program_loader.md
Name: du_program_loader

Overview:
Debug-unit front end that sits between the UART receiver and the IF stage's instruction memory.
- Takes the byte stream sent by the host: instruction count, then the program in little-endian byte order.
- Assembles 32-bit words and writes them into instruction memory.
- Then accepts execution-mode bytes and gates the pipeline enable for step-by-step or continuous execution until halt.

Parameters:
N_BITS_DATA, 8, UART byte width
NB_DATA, 32, instruction word width
ADDRWIDTH, 8, instruction memory word-address width; must be >= 8
MODE_STEP, 8'h0F, step-to-step mode byte
MODE_CONT, 8'hF0, continuous mode byte

Ports:
clock_i  in  1  system clock, single domain
reset_i  in  1  asynchronous reset, active-low
rx_valid_i  in  1  one-cycle pulse: rx_byte_i holds a new UART byte
rx_byte_i  in  N_BITS_DATA  received byte
halt_i  in  1  pipeline has decoded/retired HALT (level)
inst_we_o  out  1  instruction-memory write strobe
inst_addr_o  out  ADDRWIDTH  instruction-memory word address
inst_data_o  out  NB_DATA  word to write
enable_pipe_o  out  1  pipeline advance enable
ack_debug_o  out  1  loader ready for a mode byte
load_done_o  out  1  program fully written (sticky until reset)
end_o  out  1  execution finished (sticky until reset)
state_o  out  3  current FSM state, for debug

Behaviour:
- Reset (reset_i=0, asynchronous): state IDLE; all outputs 0; byte counter, word counter, address and shift register cleared. Reset mid-load aborts the load; no partial word is written.
- States, one-hot-encodable, 3-bit encoded on state_o: IDLE=0, LOAD=1, WRITE=2, WAIT_MODE=3, STEP=4, RUN=5, DONE=6.
- IDLE: on rx_valid_i, latch rx_byte_i as n_inst.
  - n_inst=0: go to WAIT_MODE and set load_done_o.
  - Otherwise go to LOAD.
- LOAD: each rx_valid_i shifts the byte into the word at lane byte_cnt; byte 0 lands in bits [7:0] (LSB first).
  - After the 4th byte (byte_cnt=3), go to WRITE; byte_cnt wraps to 0.
  - Cycles without rx_valid_i hold state.
- WRITE: exactly one cycle, entered the cycle after the 4th byte strobe.
  - inst_we_o=1, inst_addr_o=word_cnt, inst_data_o=assembled word.
  - Next cycle: word_cnt+1.
  - If word_cnt+1 == n_inst: go to WAIT_MODE and set load_done_o; otherwise return to LOAD.
  - An rx_valid_i arriving during WRITE is captured as byte 0 of the next word. The UART byte rate guarantees no strobe is lost.
- inst_addr_o holds its last value when idle. inst_we_o is high only in WRITE.
- WAIT_MODE: ack_debug_o=1 and enable_pipe_o=0. On rx_valid_i:
  - byte==MODE_STEP: go to STEP.
  - byte==MODE_CONT: go to RUN.
  - Any other byte: ignored, stay.
- STEP: enable_pipe_o=1 for exactly one cycle.
  - If halt_i is sampled high in that cycle: go to DONE.
  - Otherwise return to WAIT_MODE. ack_debug_o re-asserts the following cycle.
- RUN: enable_pipe_o=1 every cycle. When halt_i=1: enable_pipe_o drops the same cycle (combinational gate) and the FSM enters DONE.
- DONE: end_o=1, enable_pipe_o=0, ack_debug_o=0. All rx bytes ignored until reset.
- halt_i in IDLE/LOAD/WRITE/WAIT_MODE: ignored.
- ack_debug_o is a level output: high only in WAIT_MODE.
- Counters: word_cnt is 8-bit, so at most 255 instructions. Addresses never wrap because ADDRWIDTH>=8.

Decomposition:
- Shared package/header (parameters.vh): ADDRWIDTH, NB_DATA, MODE_STEP, MODE_CONT, state encodings.
- One natural sub-module, du_word_assembler: byte-lane shift register plus 2-bit byte counter, with a word_valid pulse out. The FSM stays in du_program_loader.

Test Plan:
1. Count 2, bytes 13 00 01 20 / 00 00 00 FC: two WRITE pulses.
   - addr 0 data 0x20010013; addr 1 data 0xFC000000.
   - load_done_o=1 and ack_debug_o=1 one cycle after the second WRITE.
2. Count 0: no inst_we_o ever; WAIT_MODE immediately with load_done_o=1.
3. After load, 3x byte 0x0F with halt_i=0: exactly three single-cycle enable_pipe_o pulses, each followed by ack_debug_o=1.
   - A 4th 0x0F with halt_i=1 gives one pulse, then DONE with end_o=1.
4. After load, byte 0xF0: enable_pipe_o held high.
   - Raise halt_i after 20 cycles: enable_pipe_o=0 that cycle, end_o=1 next cycle.
   - A later 0x0F is ignored.
5. In WAIT_MODE, byte 0x55: no state change; ack_debug_o stays 1 and enable_pipe_o stays 0.
6. Assert reset_i=0 after byte 2 of word 1 (mid-load): all outputs 0 immediately.
   - Reload count 1, bytes AA BB CC DD: single write to addr 0 of data 0xDDCCBBAA, with no stale bytes.
